// File: rtl/servo_avalon_multi.sv
// Avalon-MM slave for NUM_CH hobby servos: per-channel PWM generation and feedback pulse measurement.
// Latency: read data one cycle after cs&read; pwm_out registered, aligned with the frame counter; feedback 3 cycles.
// Backpressure: none; the slave accepts every access with zero wait states.
//
// Ports:
//   clock_clk, reset          single clock, synchronous active-high reset
//   cs/read/write/address     Avalon-MM slave access, address = {channel, offset[1:0]}
//   writedata/readdata        32-bit data; readdata is registered and held until the next read
//   pwm_response              asynchronous feedback pulses, one per channel
//   pwm_out                   servo PWM outputs, one per channel
module servo_avalon_multi #(
    parameter int  NUM_CH        = 4,
    parameter int  PERIOD_CYCLES = 1000000,
    parameter int  PW_W          = 21,
    localparam int ADDR_W        = $clog2(NUM_CH) + 2
) (
    input  logic              clock_clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [NUM_CH-1:0] pwm_response,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [PW_W-1:0] PERIOD_V = PW_W'(PERIOD_CYCLES);
    localparam logic [PW_W-1:0] LAST_CNT = PW_W'(PERIOD_CYCLES - 1);
    localparam logic [PW_W-1:0] TMO_CNT  = PW_W'(2 * PERIOD_CYCLES);
    localparam logic [PW_W-1:0] SAT_CNT  = '1;

    logic [PW_W-1:0]              cnt_q, cnt_d;
    logic [NUM_CH-1:0][PW_W-1:0]  pulse_q, pulse_d;
    logic [NUM_CH-1:0][PW_W-1:0]  active_q, active_d;
    logic [NUM_CH-1:0][PW_W-1:0]  width_q, width_d;
    logic [NUM_CH-1:0][PW_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CH-1:0][PW_W-1:0]  meas_q, meas_d;
    logic [NUM_CH-1:0]            en_q, en_d;
    logic [NUM_CH-1:0]            valid_q, valid_d;
    logic [NUM_CH-1:0]            timeout_q, timeout_d;
    logic [NUM_CH-1:0]            pwm_q, pwm_d;
    logic [NUM_CH-1:0]            sync1_q, sync2_q, sync3_q;
    logic [31:0]                  readdata_q, readdata_d;

    logic [31:0] ch_sel;
    logic [1:0]  offset;
    logic        ch_ok;
    logic        wr_en;
    logic        rd_en;
    logic        frame_wrap;
    logic        rise;
    logic        fall;
    logic        high;

    always_comb begin
        // Zero-extend before shifting so NUM_CH=1 (no channel bits) still decodes.
        ch_sel     = 32'(address) >> 2;
        offset     = address[1:0];
        ch_ok      = (ch_sel < 32'(NUM_CH));
        rd_en      = cs && read;
        wr_en      = cs && write && !read;   // a simultaneous read takes priority
        frame_wrap = (cnt_q == LAST_CNT);
        cnt_d      = frame_wrap ? '0 : cnt_q + 1'b1;

        pulse_d    = pulse_q;
        en_d       = en_q;
        active_d   = active_q;
        width_d    = width_q;
        tmo_cnt_d  = tmo_cnt_q;
        meas_d     = meas_q;
        valid_d    = valid_q;
        timeout_d  = timeout_q;
        pwm_d      = '0;
        readdata_d = readdata_q;
        rise       = 1'b0;
        fall       = 1'b0;
        high       = 1'b0;

        if (rd_en) begin
            readdata_d = 32'd0;
        end

        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && ch_ok && ch_sel == 32'(c)) begin
                if (offset == 2'd0) begin
                    pulse_d[c] = (writedata > 32'(PERIOD_CYCLES)) ? PERIOD_V : writedata[PW_W-1:0];
                end else if (offset == 2'd1) begin
                    en_d[c] = writedata[0];
                end
            end

            // Shadow load only at the frame boundary so a frame is never cut short or stretched.
            if (frame_wrap) begin
                active_d[c] = pulse_q[c];
            end
            // Use next-state values so pwm_out lines up with the frame counter and EN clears at once.
            pwm_d[c] = en_d[c] && (cnt_d < active_d[c]);

            rise = sync2_q[c] && !sync3_q[c];
            fall = !sync2_q[c] && sync3_q[c];
            high = sync2_q[c] && sync3_q[c];

            if (rise) begin
                width_d[c] = PW_W'(1);
            end else if (high && width_q[c] != SAT_CNT) begin
                width_d[c] = width_q[c] + 1'b1;
            end

            if (rise) begin
                tmo_cnt_d[c] = '0;
                timeout_d[c] = 1'b0;
            end else begin
                if (tmo_cnt_q[c] != SAT_CNT) begin
                    tmo_cnt_d[c] = tmo_cnt_q[c] + 1'b1;
                end
                if (tmo_cnt_d[c] >= TMO_CNT) begin
                    timeout_d[c] = 1'b1;
                end
            end

            if (rd_en && ch_sel == 32'(c)) begin
                case (offset)
                    2'd0: readdata_d = 32'(pulse_q[c]);
                    2'd1: readdata_d = {31'd0, en_q[c]};
                    2'd2: begin
                        readdata_d = {valid_q[c], timeout_q[c], 30'd0} | 32'(meas_q[c]);
                        valid_d[c] = 1'b0;
                    end
                    default: readdata_d = 32'(cnt_q);
                endcase
            end

            // A falling edge in the same cycle as a MEAS read keeps the new sample valid.
            if (fall) begin
                meas_d[c]  = width_q[c];
                valid_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset) begin
            cnt_q      <= '0;
            pulse_q    <= '0;
            en_q       <= '0;
            active_q   <= '0;
            width_q    <= '0;
            tmo_cnt_q  <= '0;
            meas_q     <= '0;
            valid_q    <= '0;
            timeout_q  <= '0;
            pwm_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            readdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            en_q       <= en_d;
            active_q   <= active_d;
            width_q    <= width_d;
            tmo_cnt_q  <= tmo_cnt_d;
            meas_q     <= meas_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            pwm_q      <= pwm_d;
            sync1_q    <= pwm_response;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_servo_avalon_multi.sv
module tb_servo_avalon_multi;

    localparam int P  = 100;
    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, read, write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  pwm_response;
    logic [1:0]  pwm_out;

    logic        cs3, read3, write3;
    logic [3:0]  address3;
    logic [31:0] writedata3;
    logic [31:0] readdata3;
    logic [2:0]  pwm_response3;
    logic [2:0]  pwm_out3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    servo_avalon_multi #(.NUM_CH(2), .PERIOD_CYCLES(P), .PW_W(PW)) u_dut (
        .clock_clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .pwm_response(pwm_response), .pwm_out(pwm_out)
    );

    servo_avalon_multi #(.NUM_CH(3), .PERIOD_CYCLES(P), .PW_W(PW)) u_dut3 (
        .clock_clk(clk), .reset(reset), .cs(cs3), .read(read3), .write(write3),
        .address(address3), .writedata(writedata3), .readdata(readdata3),
        .pwm_response(pwm_response3), .pwm_out(pwm_out3)
    );

    // Reference model: the frame position is simply cycles-since-reset modulo P, and
    // each channel's active width is whatever PULSE held when the frame began.
    int unsigned m_cnt;
    int unsigned m_pulse [2];
    int unsigned m_act   [2];
    bit          m_en    [2];
    logic [1:0]  m_pwm;

    always @(posedge clk) begin
        int unsigned prev_pulse [2];
        if (reset) begin
            m_cnt = 0;
            m_pwm = '0;
            for (int c = 0; c < 2; c++) begin
                m_pulse[c] = 0; m_act[c] = 0; m_en[c] = 0;
            end
        end else begin
            prev_pulse = m_pulse;
            if (cs && write && !read) begin
                if (address[1:0] == 2'd0)
                    m_pulse[address[2]] = (writedata > P) ? P : writedata;
                else if (address[1:0] == 2'd1)
                    m_en[address[2]] = writedata[0];
            end
            m_cnt = (m_cnt + 1) % P;
            if (m_cnt == 0) m_act = prev_pulse;
            for (int c = 0; c < 2; c++)
                m_pwm[c] = m_en[c] && (m_cnt < m_act[c]);
        end
    end

    // Per-frame high-cycle totals, pushed when a new frame starts.
    int hi_cnt [2];
    int fq0 [$];
    int fq1 [$];
    bit chk_pwm = 1'b0;

    always @(negedge clk) begin
        if (chk_pwm) begin
            n_checks++;
            assert (pwm_out === m_pwm) else begin
                n_errors++;
                $error("FAIL pwm_cycle observed=%b expected=%b cnt=%0d", pwm_out, m_pwm, m_cnt);
            end
        end
        if (!reset && m_cnt == 0) begin
            fq0.push_back(hi_cnt[0]);
            fq1.push_back(hi_cnt[1]);
            hi_cnt[0] = int'(pwm_out[0]);
            hi_cnt[1] = int'(pwm_out[1]);
        end else begin
            hi_cnt[0] += int'(pwm_out[0]);
            hi_cnt[1] += int'(pwm_out[1]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    // Returns the read data plus the model's frame position in the sampling cycle.
    task automatic bus_rd(input logic [2:0] a, output logic [31:0] q, output logic [31:0] fr);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; write = 1'b0; address = a;
        fr = 32'(m_cnt);
        @(negedge clk);
        q = readdata;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic wait_cnt(input int unsigned v);
        bit hit = 1'b0;
        for (int i = 0; i < 3 * P && !hit; i++) begin
            @(negedge clk);
            if (m_cnt == v) hit = 1'b1;
        end
        chk("wait_frame_pos", 32'(hit), 32'd1);
    endtask

    task automatic wait_frames(input int n);
        bit hit = 1'b0;
        for (int i = 0; i < (n + 2) * P && !hit; i++) begin
            @(negedge clk);
            if (fq0.size() >= n) hit = 1'b1;
        end
        chk("wait_frames", 32'(hit), 32'd1);
    endtask

    task automatic fb_pulse(input int ch, input int w);
        @(negedge clk);
        pwm_response[ch] = 1'b1;
        repeat (w) @(negedge clk);
        pwm_response[ch] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] q, fr;
        int          w, ch, v;

        reset = 1'b1; cs = 0; read = 0; write = 0; address = '0; writedata = '0;
        pwm_response = '0;
        cs3 = 0; read3 = 0; write3 = 0; address3 = '0; writedata3 = '0; pwm_response3 = '0;
        repeat (3) @(negedge clk);
        chk_pwm = 1'b1;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        reset = 1'b0;

        bus_rd(3'b0_00, q, fr); chk("reset_pulse0", q, 32'd0);
        bus_rd(3'b0_01, q, fr); chk("reset_ctrl0", q, 32'd0);
        bus_rd(3'b0_10, q, fr); chk("reset_meas0", q, 32'd0);
        bus_rd(3'b0_11, q, fr); chk("frame_read", q, fr);

        // PULSE0=30 with EN: each full frame carries exactly 30 high cycles.
        bus_wr(3'b0_00, 32'd30);
        bus_wr(3'b0_01, 32'd1);
        wait_cnt(0); wait_cnt(5);
        fq0.delete();
        wait_frames(1);
        chk("frame_hi_30", 32'(fq0[0]), 32'd30);

        // Mid-frame change: current frame stays 30, the next one becomes 60.
        wait_cnt(40);
        fq0.delete();
        bus_wr(3'b0_00, 32'd60);
        wait_frames(2);
        chk("midframe_keep_30", 32'(fq0[0]), 32'd30);
        chk("next_frame_60", 32'(fq0[1]), 32'd60);

        // Clamp on write, then a full-width pulse is constantly high.
        bus_wr(3'b1_00, 32'd500);
        bus_rd(3'b1_00, q, fr); chk("clamp_readback", q, 32'd100);
        bus_wr(3'b1_01, 32'd1);
        bus_rd(3'b1_01, q, fr); chk("ctrl1_readback", q, 32'd1);
        wait_cnt(1);
        fq1.delete(); fq0.delete();
        wait_frames(1);
        chk("frame_hi_100", 32'(fq1[0]), 32'd100);

        // Simultaneous read and write: the read is served and the write dropped.
        @(negedge clk);
        cs = 1; read = 1; write = 1; address = 3'b0_00; writedata = 32'd5;
        @(negedge clk);
        chk("rw_read_wins", readdata, 32'd60);
        cs = 0; read = 0; write = 0;
        repeat (3) @(negedge clk);
        chk("readdata_holds", readdata, 32'd60);
        bus_rd(3'b0_00, q, fr); chk("rw_write_dropped", q, 32'd60);

        // Channel 0 has seen no edge since reset (well over 2*P cycles).
        bus_rd(3'b0_10, q, fr); chk("meas0_timeout", q, 32'h4000_0000);
        fb_pulse(0, 10);
        bus_rd(3'b0_10, q, fr); chk("meas0_edge_clears_tmo", q, 32'h8000_000A);

        fb_pulse(1, 42);
        bus_rd(3'b1_10, q, fr); chk("meas1_valid", q, 32'h8000_002A);
        bus_rd(3'b1_10, q, fr); chk("meas1_reread", q, 32'h0000_002A);

        // Randomised register traffic and feedback widths.
        for (int i = 0; i < 16; i++) begin
            ch = int'($urandom_range(0, 1));
            w  = int'($urandom_range(1, 80));
            fb_pulse(ch, w);
            bus_rd({ch[0], 2'b10}, q, fr); chk("rand_meas", q, 32'h8000_0000 | 32'(w));
            v = int'($urandom_range(0, 130));
            bus_wr({ch[0], 2'b00}, 32'(v));
            bus_rd({ch[0], 2'b00}, q, fr); chk("rand_pulse", q, (v > P) ? 32'(P) : 32'(v));
            v = int'($urandom);
            bus_wr({ch[0], 2'b01}, 32'(v));
            bus_rd({ch[0], 2'b01}, q, fr); chk("rand_ctrl", q, 32'(v & 1));
            bus_rd({ch[0], 2'b11}, q, fr); chk("rand_frame", q, fr);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end

        // Out-of-range channel on the 3-channel instance: writes ignored, reads zero.
        @(negedge clk);
        cs3 = 1; write3 = 1; address3 = 4'b11_00; writedata3 = 32'd77;
        @(negedge clk);
        write3 = 0; read3 = 1; address3 = 4'b11_00;
        @(negedge clk);
        chk("oor_pulse", readdata3, 32'd0);
        address3 = 4'b11_11;
        @(negedge clk);
        chk("oor_frame", readdata3, 32'd0);
        address3 = 4'b10_11;
        @(negedge clk);
        chk("inrange_frame_nonzero", 32'(readdata3 != 0), 32'd1);
        cs3 = 0; read3 = 0;

        // Reset while channel 1 output and feedback are both high.
        bus_wr(3'b1_00, 32'd100);
        bus_wr(3'b1_01, 32'd1);
        wait_cnt(2); wait_cnt(2);
        bus_rd(3'b1_00, q, fr); chk("pre_reset_pulse1", q, 32'd100);
        @(negedge clk);
        pwm_response[1] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_pwm", 32'(pwm_out), 32'd0);
        chk("midreset_readdata", readdata, 32'd0);
        pwm_response[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        bus_rd(3'b1_10, q, fr); chk("post_reset_meas1", q, 32'd0);
        bus_rd(3'b1_00, q, fr); chk("post_reset_pulse1", q, 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
